mips_irq_ctl: RTL and testbench

//  Parametrised interrupt controller for the MIPS789 system, replacing the single fixed irq_req/irq_addr pair

---
 rtl/mips_irq_ctl_if.sv | 22 ++
 rtl/mips_irq_ctl.sv | 136 +++++++++++++
 tb/tb_mips_irq_ctl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mips_irq_ctl_if.sv
// Bus window and interrupt handshake between the MIPS789 core side and mips_irq_ctl.
// The controller uses the slave modport; the core/device-bus side uses master.
interface mips_irq_ctl_if;
   logic [31:0] addr;
   logic [31:0] din;
   logic        we;
   logic        re;
   logic [31:0] dout;
   logic        irq_req_o;
   logic [31:0] irq_addr_o;
   logic        irq_ack_i;

   modport slave (
      input  addr, din, we, re, irq_ack_i,
      output dout, irq_req_o, irq_addr_o
   );

   modport master (
      output addr, din, we, re, irq_ack_i,
      input  dout, irq_req_o, irq_addr_o
   );
endinterface

// File: rtl/mips_irq_ctl.sv
// Fixed-priority interrupt controller: synchronised sources, edge/level pending, mask,
// global enable, register window on the coprocessor bus and a req/ack vector handshake.
module mips_irq_ctl #(
   parameter int          N_SRC      = 8,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0050,
   parameter int          VEC_STRIDE = 8,
   parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src_i,
   mips_irq_ctl_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   state_t           r_state;
   logic [N_SRC-1:0] r_s1, r_s2, r_s3;
   logic [N_SRC-1:0] r_pend_e, r_mask, r_mode;
   logic             r_en;
   logic [4:0]       r_idx;
   logic             r_req;
   logic [31:0]      r_addr;
   logic [31:0]      r_dout;

   logic             w_hit;
   logic [7:0]       w_off;
   logic [N_SRC-1:0] w_edge, w_pend, w_elig, w_w1c, w_ack_clr;
   logic [4:0]       w_idx;
   logic             w_ack_ok;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_hit    = (bus.addr[31:8] == BASE_ADDR[31:8]);
   assign w_off    = bus.addr[7:0];
   assign w_unused = ^bus.din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= irq_src_i;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_edge   = r_s2 & ~r_s3;
   assign w_pend   = (r_mode & r_pend_e) | (~r_mode & r_s2);
   assign w_elig   = w_pend & r_mask & {N_SRC{r_en}};
   assign w_ack_ok = (r_state == REQ) && bus.irq_ack_i;
   assign w_w1c    = (bus.we && w_hit && w_off == 8'h00) ? bus.din[N_SRC-1:0] : '0;

   always_comb begin
      w_ack_clr = '0;
      for (int i = 0; i < N_SRC; i++)
         w_ack_clr[i] = w_ack_ok && (r_idx == 5'(i));
   end

   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      w_idx = '0;
      for (int i = N_SRC-1; i >= 0; i--)
         if (w_elig[i]) w_idx = 5'(i);
   end

   // New edge beats a same-cycle W1C/ack; level-mode bits never latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pend_e <= '0;
      else     r_pend_e <= ((r_pend_e & ~(w_w1c | w_ack_clr)) | w_edge) & r_mode;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mask <= '0;
         r_mode <= '0;
         r_en   <= 1'b0;
      end else if (bus.we && w_hit) begin
         case (w_off)
            8'h04:   r_mask <= bus.din[N_SRC-1:0];
            8'h08:   r_mode <= bus.din[N_SRC-1:0];
            8'h0C:   r_en   <= bus.din[0];
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rdata = '0;
      case (w_off)
         8'h00:   w_rdata = 32'(w_pend);
         8'h04:   w_rdata = 32'(r_mask);
         8'h08:   w_rdata = 32'(r_mode);
         8'h0C:   w_rdata = {31'b0, r_en};
         8'h10:   w_rdata = {(r_state == REQ), 26'b0, r_idx};
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_dout <= '0;
      else if (bus.re) r_dout <= w_hit ? w_rdata : 32'h0;
   end

   // Request is latched in IDLE and held untouched until acknowledged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_req   <= 1'b0;
         r_addr  <= VEC_BASE;
      end else begin
         case (r_state)
            IDLE: if (|w_elig) begin
               r_idx   <= w_idx;
               r_addr  <= VEC_BASE + 32'(w_idx) * 32'(VEC_STRIDE);
               r_req   <= 1'b1;
               r_state <= REQ;
            end
            REQ: if (bus.irq_ack_i) begin
               r_req   <= 1'b0;
               r_state <= GAP;
            end
            GAP:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.dout       = r_dout;
   assign bus.irq_req_o  = r_req;
   assign bus.irq_addr_o = r_addr;

endmodule

// File: tb/tb_mips_irq_ctl.sv
// Directed bench for mips_irq_ctl: expected values are queued as each step is driven
// and popped when the DUT output is sampled on the falling edge.
module tb_mips_irq_ctl;
   localparam int          N_SRC = 8;
   localparam logic [31:0] BASE  = 32'hFFFF_FF00;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N_SRC-1:0] src = '0;

   mips_irq_ctl_if bus ();

   mips_irq_ctl #(.N_SRC(N_SRC)) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_src_i (src),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int          nvec  = 0;
   int          nfail = 0;
   logic [31:0] q_exp[$];

   task automatic expect_v(input logic [31:0] v);
      q_exp.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] ev;
      nvec++;
      if (q_exp.size() == 0) begin
         nfail++;
         $error("FAIL %s: got %h, scoreboard empty", tag, obs);
      end else begin
         ev = q_exp.pop_front();
         assert (obs === ev) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, ev);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr = a;
      bus.din  = d;
      bus.we   = 1'b1;
      @(negedge clk);
      bus.we   = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] ev);
      expect_v(ev);
      bus.addr = a;
      bus.re   = 1'b1;
      @(negedge clk);
      bus.re   = 1'b0;
      chk(tag, bus.dout);
   endtask

   task automatic chk_req(input string tag, input logic ev);
      expect_v({31'b0, ev});
      chk(tag, {31'b0, bus.irq_req_o});
   endtask

   task automatic chk_vec(input string tag, input logic [31:0] ev);
      expect_v(ev);
      chk(tag, bus.irq_addr_o);
   endtask

   task automatic wait_req(input int budget);
      for (int i = 0; i < budget && !bus.irq_req_o; i++) @(negedge clk);
      chk_req("req_timeout", 1'b1);
   endtask

   task automatic ack();
      bus.irq_ack_i = 1'b1;
      @(negedge clk);
      bus.irq_ack_i = 1'b0;
   endtask

   initial begin
      bus.addr = '0; bus.din = '0; bus.we = 1'b0; bus.re = 1'b0; bus.irq_ack_i = 1'b0;
      cyc(2);
      rst = 1'b0;
      chk_req("rst_req", 1'b0);
      chk_vec("rst_vec", 32'h50);
      expect_v(32'h0); chk("rst_dout", bus.dout);

      // Edge source 3
      wr(BASE | 8'h04, 32'h08);
      wr(BASE | 8'h08, 32'h08);
      wr(BASE | 8'h0C, 32'h01);
      src[3] = 1'b1;
      cyc(3); chk_req("lat_before", 1'b0);
      cyc(1); chk_req("lat_at4", 1'b1);
      chk_vec("vec3", 32'h68);
      rd("pend3", BASE | 8'h00, 32'h08);
      rd("stat_busy", BASE | 8'h10, 32'h8000_0003);
      ack();
      src[3] = 1'b0;
      chk_req("ack3_drop", 1'b0);
      rd("pend3_clr", BASE | 8'h00, 32'h0);
      rd("stat_idle", BASE | 8'h10, 32'h3);

      // Priority: sources 2 and 5 together
      wr(BASE | 8'h04, 32'h24);
      wr(BASE | 8'h08, 32'h24);
      src[2] = 1'b1; src[5] = 1'b1;
      wait_req(10);
      chk_vec("prio_first", 32'h60);
      ack();
      chk_req("gap1", 1'b0);
      cyc(1); chk_req("gap2", 1'b0);
      cyc(1); chk_req("b2b_req", 1'b1);
      chk_vec("prio_second", 32'h78);
      ack();
      src[2] = 1'b0; src[5] = 1'b0;
      cyc(3);

      // Level source 0
      wr(BASE | 8'h08, 32'h00);
      wr(BASE | 8'h04, 32'h01);
      src[0] = 1'b1;
      wait_req(10);
      chk_vec("lvl_vec", 32'h50);
      ack();
      chk_req("lvl_gap1", 1'b0);
      cyc(1); chk_req("lvl_gap2", 1'b0);
      cyc(1); chk_req("lvl_rereq", 1'b1);
      src[0] = 1'b0;
      cyc(3);
      ack();
      cyc(4); chk_req("lvl_done", 1'b0);

      // Masked edge source 1
      wr(BASE | 8'h04, 32'h00);
      wr(BASE | 8'h08, 32'h02);
      src[1] = 1'b1;
      cyc(6); chk_req("masked_noreq", 1'b0);
      rd("masked_pend", BASE | 8'h00, 32'h02);
      wr(BASE | 8'h04, 32'h02);
      cyc(1); chk_req("unmask_req", 1'b1);
      chk_vec("vec1", 32'h58);
      ack();
      src[1] = 1'b0;
      rd("pend1_clr", BASE | 8'h00, 32'h0);

      // W1C racing an edge on source 4
      wr(BASE | 8'h04, 32'h00);
      wr(BASE | 8'h08, 32'h10);
      src[4] = 1'b1;
      cyc(2);
      wr(BASE | 8'h00, 32'h10);
      rd("w1c_race", BASE | 8'h00, 32'h10);
      wr(32'h0000_0004, 32'hFF);
      rd("miss_wr", BASE | 8'h04, 32'h00);
      rd("unmapped", BASE | 8'h14, 32'h0);
      rd("miss_rd", 32'h0000_0000, 32'h0);

      // Reset in the middle of a request
      wr(BASE | 8'h04, 32'h10);
      cyc(1); chk_req("req4", 1'b1);
      chk_vec("vec4", 32'h70);
      src[4] = 1'b0;
      rd("stat4", BASE | 8'h10, 32'h8000_0004);
      #2 rst = 1'b1;
      #1;
      chk_req("mid_rst_req", 1'b0);
      chk_vec("mid_rst_vec", 32'h50);
      expect_v(32'h0); chk("mid_rst_dout", bus.dout);
      @(negedge clk);
      rst = 1'b0;
      rd("rst_pend", BASE | 8'h00, 32'h0);
      rd("rst_mask", BASE | 8'h04, 32'h0);
      rd("rst_mode", BASE | 8'h08, 32'h0);
      rd("rst_ctrl", BASE | 8'h0C, 32'h0);
      cyc(4); chk_req("rst_quiet", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end
endmodule
